// File: rtl/vram_write_ctrl_if.sv
// CPU snoop bus and VRAM writer-side signals for vram_write_ctrl.
interface vram_write_ctrl_if;
  logic [9:0]  hCount;
  logic [22:0] cpuAddr;
  logic [15:0] cpuData;
  logic        nAS;
  logic        nUDS;
  logic        nLDS;
  logic        cpuRnW;
  logic [14:0] vramWrAddr;
  logic [7:0]  vramWrData;
  logic        vramWrSel;
  logic        nvramWE;
  logic        fifoEmpty;
  logic        overflow;

  modport master (
    output hCount, cpuAddr, cpuData, nAS, nUDS, nLDS, cpuRnW,
    input  vramWrAddr, vramWrData, vramWrSel, nvramWE, fifoEmpty, overflow
  );

  modport slave (
    input  hCount, cpuAddr, cpuData, nAS, nUDS, nLDS, cpuRnW,
    output vramWrAddr, vramWrData, vramWrSel, nvramWE, fifoEmpty, overflow
  );
endinterface

// File: rtl/vram_write_ctrl.sv
// Snoops 68000 writes to the screen buffer, queues bytes, and drains them
// into VRAM during pixel-clock slots the video fetch never uses.
module vram_write_ctrl #(
  parameter logic [23:0] FB_BASE    = 24'h3FA700,
  parameter int unsigned FB_BYTES   = 21888,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic             pixClock,
  input  logic             reset,
  vram_write_ctrl_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [23:0] FB_BYTES_W = 24'(FB_BYTES);

  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
  } fifo_entry_t;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_PUSH2, S_WAIT_END} state_t;

  state_t      state_q, state_d;
  logic [1:0]  nas_sync_q, nas_sync_d;
  logic [1:0]  uds_sync_q, uds_sync_d;
  logic [1:0]  lds_sync_q, lds_sync_d;
  logic [1:0]  rnw_sync_q, rnw_sync_d;
  fifo_entry_t odd_entry_q, odd_entry_d;
  logic        overflow_q, overflow_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [14:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        wr_sel_q, wr_sel_d;
  logic        nwe_q, nwe_d;
  logic        active_q, active_d;

  fifo_entry_t fifo_mem_q [FIFO_DEPTH];
  fifo_entry_t push_entry;
  logic        push, pop;

  logic        nas_s, uds_act, lds_act, rnw_s;
  logic [23:0] full_addr, byte_off, odd_off;
  logic        even_hit, odd_hit, cyc_hit, fifo_empty;
  logic [CNT_W-1:0] n_bytes, free_cnt;
  logic [2:0]  slot;
  logic        unused_hcount_hi;

  assign nas_s     = nas_sync_q[1];
  assign rnw_s     = rnw_sync_q[1];
  assign uds_act   = ~uds_sync_q[1];
  assign lds_act   = ~lds_sync_q[1];
  assign slot      = bus.hCount[2:0];
  assign unused_hcount_hi = ^bus.hCount[9:3];

  // Screen-buffer decode on the raw (strobe-qualified, stable) CPU address.
  assign full_addr = {bus.cpuAddr, 1'b0};
  assign byte_off  = full_addr - FB_BASE;
  assign odd_off   = byte_off + 24'd1;
  assign even_hit  = (full_addr >= FB_BASE) && (byte_off < FB_BYTES_W);
  assign odd_hit   = even_hit && (odd_off < FB_BYTES_W);
  assign cyc_hit   = (uds_act || lds_act) && (!uds_act || even_hit) && (!lds_act || odd_hit);
  assign n_bytes   = CNT_W'(uds_act) + CNT_W'(lds_act);
  assign free_cnt  = CNT_W'(FIFO_DEPTH) - count_q;
  assign fifo_empty = (count_q == '0);

  always_comb begin
    state_d     = state_q;
    nas_sync_d  = {nas_sync_q[0], bus.nAS};
    uds_sync_d  = {uds_sync_q[0], bus.nUDS};
    lds_sync_d  = {lds_sync_q[0], bus.nLDS};
    rnw_sync_d  = {rnw_sync_q[0], bus.cpuRnW};
    odd_entry_d = odd_entry_q;
    overflow_d  = overflow_q;
    push        = 1'b0;
    push_entry  = '0;
    pop         = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_sel_d    = 1'b0;
    nwe_d       = 1'b1;
    active_d    = 1'b0;

    // Capture FSM: at most one CPU bus cycle enqueued per nAS assertion.
    case (state_q)
      S_IDLE: begin
        if (!nas_s && !rnw_s && (uds_act || lds_act)) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_WAIT_END;
        if (cyc_hit) begin
          if (free_cnt < n_bytes) begin
            overflow_d = 1'b1;
          end else begin
            push = 1'b1;
            if (uds_act) push_entry = '{addr: byte_off[14:0], data: bus.cpuData[15:8]};
            else         push_entry = '{addr: odd_off[14:0],  data: bus.cpuData[7:0]};
            if (uds_act && lds_act) begin
              odd_entry_d = '{addr: odd_off[14:0], data: bus.cpuData[7:0]};
              state_d     = S_PUSH2;
            end
          end
        end
      end
      S_PUSH2: begin
        push       = 1'b1;
        push_entry = odd_entry_q;
        state_d    = S_WAIT_END;
      end
      default: begin
        if (nas_s) state_d = S_IDLE;
      end
    endcase

    // Drain slots: setup 2/5, strobe 3/6, release elsewhere.
    case (slot)
      3'd2, 3'd5: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          wr_addr_d = fifo_mem_q[rd_ptr_q].addr;
          wr_data_d = fifo_mem_q[rd_ptr_q].data;
          wr_sel_d  = 1'b1;
          active_d  = 1'b1;
        end
      end
      3'd3, 3'd6: begin
        if (active_q) begin
          wr_sel_d = 1'b1;
          nwe_d    = 1'b0;
          active_d = 1'b1;
        end
      end
      default: ;
    endcase

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge pixClock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      nas_sync_q  <= 2'b11;
      uds_sync_q  <= 2'b11;
      lds_sync_q  <= 2'b11;
      rnw_sync_q  <= 2'b11;
      odd_entry_q <= '0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_sel_q    <= 1'b0;
      nwe_q       <= 1'b1;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      nas_sync_q  <= nas_sync_d;
      uds_sync_q  <= uds_sync_d;
      lds_sync_q  <= lds_sync_d;
      rnw_sync_q  <= rnw_sync_d;
      odd_entry_q <= odd_entry_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_sel_q    <= wr_sel_d;
      nwe_q       <= nwe_d;
      active_q    <= active_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge pixClock) begin
    if (push && !reset) fifo_mem_q[wr_ptr_q] <= push_entry;
  end

  assign bus.vramWrAddr = wr_addr_q;
  assign bus.vramWrData = wr_data_q;
  assign bus.vramWrSel  = wr_sel_q;
  assign bus.nvramWE    = nwe_q;
  assign bus.fifoEmpty  = fifo_empty;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_vram_write_ctrl.sv
// Scoreboard bench for vram_write_ctrl: directed CPU cycles, monitor checks VRAM writes.
module tb_vram_write_ctrl;
  logic pixClock = 1'b0;
  logic reset;
  vram_write_ctrl_if bus_if ();

  vram_write_ctrl dut (
    .pixClock (pixClock),
    .reset    (reset),
    .bus      (bus_if)
  );

  always #5 pixClock = ~pixClock;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [22:0] exp_q [$];
  logic        hold_req    = 1'b0;
  logic [9:0]  hc_edge     = '0;
  logic        mon_on      = 1'b0;
  logic        mon_we_prev = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic push_exp(input logic [14:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // hCount free-runs; with hold_req it parks at a value whose low bits are 0.
  initial begin
    bus_if.hCount = '0;
    forever begin
      @(posedge pixClock);
      #2;
      hc_edge = bus_if.hCount;
      if (!(hold_req && bus_if.hCount[2:0] == 3'd0)) bus_if.hCount = bus_if.hCount + 10'd1;
    end
  end

  // Monitor: slot legality every cycle, scoreboard pop on each write strobe.
  initial begin
    logic [22:0] e;
    wait (mon_on);
    forever begin
      @(negedge pixClock);
      if (!(hc_edge[2:0] == 3'd3 || hc_edge[2:0] == 3'd6))
        check("nwe_outside_strobe_slot", 32'(bus_if.nvramWE), 32'd1);
      if (hc_edge[2:0] == 3'd0 || hc_edge[2:0] == 3'd1 || hc_edge[2:0] == 3'd7)
        check("sel_in_reserved_slot", 32'(bus_if.vramWrSel), 32'd0);
      if (bus_if.nvramWE === 1'b0 && mon_we_prev) begin
        check("sel_during_we", 32'(bus_if.vramWrSel), 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                   bus_if.vramWrAddr, bus_if.vramWrData);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(bus_if.vramWrAddr), 32'(e[22:8]));
          check("wr_data", 32'(bus_if.vramWrData), 32'(e[7:0]));
        end
      end
      mon_we_prev = (bus_if.nvramWE !== 1'b0);
    end
  end

  task automatic cpu_cycle(input logic [22:0] a, input logic [15:0] d,
                           input logic uds, input logic lds, input logic rnw);
    @(negedge pixClock);
    bus_if.cpuAddr = a;
    bus_if.cpuData = d;
    bus_if.cpuRnW  = rnw;
    bus_if.nAS     = 1'b0;
    bus_if.nUDS    = ~uds;
    bus_if.nLDS    = ~lds;
    repeat (10) @(negedge pixClock);
    bus_if.nAS  = 1'b1;
    bus_if.nUDS = 1'b1;
    bus_if.nLDS = 1'b1;
    bus_if.cpuRnW = 1'b1;
    repeat (6) @(negedge pixClock);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge pixClock);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (24) @(negedge pixClock);
    check("fifo_empty_after_drain", 32'(bus_if.fifoEmpty), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    reset = 1'b1;
    bus_if.cpuAddr = '0;
    bus_if.cpuData = '0;
    bus_if.nAS     = 1'b1;
    bus_if.nUDS    = 1'b1;
    bus_if.nLDS    = 1'b1;
    bus_if.cpuRnW  = 1'b1;
    repeat (4) @(negedge pixClock);
    check("rst_addr",     32'(bus_if.vramWrAddr), 32'd0);
    check("rst_data",     32'(bus_if.vramWrData), 32'd0);
    check("rst_sel",      32'(bus_if.vramWrSel),  32'd0);
    check("rst_nwe",      32'(bus_if.nvramWE),    32'd1);
    check("rst_empty",    32'(bus_if.fifoEmpty),  32'd1);
    check("rst_overflow", 32'(bus_if.overflow),   32'd0);
    reset  = 1'b0;
    mon_on = 1'b1;

    // Word write at buffer start: even byte first.
    push_exp(15'h0000, 8'hA5);
    push_exp(15'h0001, 8'h5A);
    cpu_cycle(23'h1FD380, 16'hA55A, 1'b1, 1'b1, 1'b0);
    wait_drain();

    // LDS-only byte lands on the odd address.
    push_exp(15'h0041, 8'h3C);
    cpu_cycle(23'h1FD3A0, 16'h003C, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // Just below the buffer: ignored.
    cpu_cycle(23'h1FD37F, 16'hDEAD, 1'b1, 1'b1, 1'b0);
    wait_drain();

    // Last word of the buffer.
    push_exp(15'h557E, 8'h12);
    push_exp(15'h557F, 8'h34);
    cpu_cycle(23'h1FFE3F, 16'h1234, 1'b1, 1'b1, 1'b0);
    wait_drain();

    // First byte past the end: miss, not an overflow.
    cpu_cycle(23'h1FFE40, 16'h7700, 1'b1, 1'b0, 1'b0);
    wait_drain();
    check("past_end_no_overflow", 32'(bus_if.overflow), 32'd0);

    // Read cycle never enqueues.
    @(negedge pixClock);
    bus_if.cpuAddr = 23'h1FD380;
    bus_if.cpuRnW  = 1'b1;
    bus_if.nAS     = 1'b0;
    bus_if.nUDS    = 1'b0;
    bus_if.nLDS    = 1'b0;
    repeat (12) begin
      @(negedge pixClock);
      check("read_fifo_empty", 32'(bus_if.fifoEmpty), 32'd1);
      check("read_nwe",        32'(bus_if.nvramWE),   32'd1);
    end
    bus_if.nAS  = 1'b1;
    bus_if.nUDS = 1'b1;
    bus_if.nLDS = 1'b1;
    repeat (6) @(negedge pixClock);

    // Park on the fetch slot and overfill: fifth word dropped whole.
    hold_req = 1'b1;
    repeat (12) @(negedge pixClock);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        push_exp(15'(16'h0100 + 16'(2 * i)), 8'(8'h10 + 8'(i)));
        push_exp(15'(16'h0101 + 16'(2 * i)), 8'(8'h20 + 8'(i)));
      end
      cpu_cycle(23'(23'h1FD400 + 23'(i)), {8'(8'h10 + 8'(i)), 8'(8'h20 + 8'(i))},
                1'b1, 1'b1, 1'b0);
    end
    check("full_overflow_set", 32'(bus_if.overflow),  32'd1);
    check("full_not_empty",    32'(bus_if.fifoEmpty), 32'd0);
    hold_req = 1'b0;
    wait_drain();
    check("overflow_sticky", 32'(bus_if.overflow), 32'd1);

    // Queue 3 bytes, then reset on a setup slot: everything is flushed.
    hold_req = 1'b1;
    repeat (12) @(negedge pixClock);
    cpu_cycle(23'h1FD480, 16'hBEEF, 1'b1, 1'b1, 1'b0);
    cpu_cycle(23'h1FD481, 16'h0077, 1'b0, 1'b1, 1'b0);
    check("pre_reset_not_empty", 32'(bus_if.fifoEmpty), 32'd0);
    hold_req = 1'b0;
    t = 0;
    while (bus_if.hCount[2:0] != 3'd2 && t < 16) begin
      @(negedge pixClock);
      t++;
    end
    check("reset_slot_found", 32'(bus_if.hCount[2:0]), 32'd2);
    reset = 1'b1;
    @(negedge pixClock);
    check("midrst_nwe",      32'(bus_if.nvramWE),   32'd1);
    check("midrst_sel",      32'(bus_if.vramWrSel), 32'd0);
    check("midrst_empty",    32'(bus_if.fifoEmpty), 32'd1);
    check("midrst_overflow", 32'(bus_if.overflow),  32'd0);
    reset = 1'b0;
    repeat (64) @(negedge pixClock);
    check("post_rst_empty", 32'(bus_if.fifoEmpty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
